ad9280_trig_ctrl: RTL and testbench

Capture sequencer for the AD9280 oscilloscope channel. It decimates the 8-bit ADC sample stream and writes samples circularly into the capture buffer RAM. It holds a programmable pre-trigger depth, detects a level/edge trigger (or forces one in auto mode), completes the post-trigger fill, and reports done, trigger address and an interrupt to the AXI4-Lite register file. It sits between the ADC input stage, the capture buffer and the register block.

---
 rtl/ad9280_scop_pkg.sv | 37 +++
 rtl/ad9280_decim.sv | 32 +++
 rtl/ad9280_trig_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_ad9280_trig_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9280_scop_pkg.sv
// Shared types and defaults for the AD9280 scope channel.
// Used by the capture sequencer and the register block.
package ad9280_scop_pkg;

    localparam int SCOP_DATA_W = 8;
    localparam int SCOP_ADDR_W = 10;
    localparam int SCOP_TMO_W  = 24;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } trig_state_e;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;
    localparam logic MODE_AUTO = 1'b1;

    // Edge test on pre-computed "sample >= level" flags.
    function automatic logic trig_hit(
        input logic edge_sel,
        input logic prev_ge,
        input logic cur_ge
    );
        logic hit;
        hit = 1'b0;
        case (edge_sel)
            EDGE_RISE: hit = !prev_ge && cur_ge;
            EDGE_FALL: hit = prev_ge && !cur_ge;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ad9280_decim.sv
// Sample decimator: keeps 1 of every decim+1 valid samples.
// The first valid after clr is always accepted.
module ad9280_decim
    import ad9280_scop_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        valid,
    input  logic [15:0] decim,
    output logic        accept
);

    logic [15:0] cnt;

    assign accept = en && valid && (cnt == '0);

    // Reload on accept, count down on skipped samples.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && valid) begin
            if (cnt == '0) begin
                cnt <= decim;
            end else begin
                cnt <= cnt - 16'd1;
            end
        end
    end

endmodule

// File: rtl/ad9280_trig_ctrl.sv
// Capture sequencer: circular buffer fill with pre-trigger depth,
// level/edge trigger, auto-mode timeout and done/irq reporting.
module ad9280_trig_ctrl
    import ad9280_scop_pkg::*;
#(
    parameter int DATA_W = SCOP_DATA_W,
    parameter int ADDR_W = SCOP_ADDR_W,
    parameter int TMO_W  = SCOP_TMO_W
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              cfg_arm,
    input  logic              cfg_abort,
    input  logic [DATA_W-1:0] cfg_level,
    input  logic              cfg_edge,
    input  logic              cfg_auto,
    input  logic [ADDR_W-1:0] cfg_pre_len,
    input  logic [15:0]       cfg_decim,
    input  logic [TMO_W-1:0]  cfg_timeout,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              st_busy,
    output logic              st_done,
    output logic              st_forced,
    output logic [ADDR_W-1:0] st_trig_addr,
    output logic [2:0]        st_state,
    output logic              irq
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    trig_state_e state_q, state_d;

    logic [DATA_W-1:0] level_q;
    logic              edge_q;
    logic              auto_q;
    logic [ADDR_W-1:0] pre_q;
    logic [15:0]       decim_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [TMO_W-1:0]  tmo_cnt;

    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  post_len;
    logic [DATA_W-1:0] prev_q;
    logic              prev_vld;
    logic              fin_q;

    logic arm_go, abort_go, busy, en, accept;
    logic real_hit, expired, fire, done_go;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              done_q;
    logic              forced_q;
    logic              irq_q;
    logic [ADDR_W-1:0] trig_q;

    assign busy = (state_q == ST_PRE)
               || (state_q == ST_WAIT)
               || (state_q == ST_POST);

    assign arm_go = cfg_arm && !cfg_abort
                 && ((state_q == ST_IDLE)
                  || (state_q == ST_DONE));

    assign abort_go = cfg_abort && (state_q != ST_IDLE);

    // No sample is taken once the last write is in flight.
    assign en = busy && !fin_q && !cfg_abort;

    assign cnt_nxt  = cnt_q + CNT_W'(1);
    assign post_len = CNT_W'(DEPTH) - {1'b0, pre_q};

    assign real_hit = prev_vld && trig_hit(
        edge_q, prev_q >= level_q, adc_data >= level_q);

    assign expired = (auto_q == MODE_AUTO)
                  && (tmo_cnt >= tmo_q);

    assign fire = (state_q == ST_WAIT) && accept
               && (real_hit || expired);

    assign done_go = (state_q == ST_POST) && fin_q
                  && !cfg_abort;

    ad9280_decim u_decim (
        .clk    (ACLK),
        .rst    (ARESET),
        .clr    (arm_go),
        .en     (en),
        .valid  (adc_valid),
        .decim  (decim_q),
        .accept (accept)
    );

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_d = state_q;
        if (abort_go) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_go) begin
                        state_d = (cfg_pre_len == '0)
                                ? ST_WAIT : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (accept && cnt_nxt == {1'b0, pre_q}) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fire) begin
                        state_d = ST_POST;
                    end
                end
                ST_POST: begin
                    if (fin_q) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Config latch; an ADDR_W-wide pre_len never exceeds DEPTH-1.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            level_q <= '0;
            edge_q  <= 1'b0;
            auto_q  <= 1'b0;
            pre_q   <= '0;
            decim_q <= '0;
            tmo_q   <= '0;
        end else if (arm_go) begin
            level_q <= cfg_level;
            edge_q  <= cfg_edge;
            auto_q  <= cfg_auto;
            pre_q   <= cfg_pre_len;
            decim_q <= cfg_decim;
            tmo_q   <= cfg_timeout;
        end
    end

    // Registered buffer write port and previous-sample tracking.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_addr  <= '0;
            prev_q   <= '0;
            prev_vld <= 1'b0;
        end else begin
            we_q <= accept;
            if (arm_go) begin
                wr_addr  <= '0;
                prev_vld <= 1'b0;
            end else if (accept) begin
                addr_q   <= wr_addr;
                wdata_q  <= adc_data;
                wr_addr  <= wr_addr + ADDR_W'(1);
                prev_q   <= adc_data;
                prev_vld <= 1'b1;
            end
        end
    end

    // Sample counter, final-write flag and WAIT timeout counter.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            tmo_cnt <= '0;
        end else if (arm_go || abort_go) begin
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (state_q == ST_WAIT && tmo_cnt < tmo_q) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (done_go) begin
                fin_q <= 1'b0;
            end
            if (fire) begin
                cnt_q <= CNT_W'(1);
                fin_q <= (post_len == CNT_W'(1));
            end else if (accept) begin
                cnt_q <= cnt_nxt;
                if (state_q == ST_POST && cnt_nxt == post_len) begin
                    fin_q <= 1'b1;
                end
            end
        end
    end

    // Status flags, trigger address and done interrupt.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            done_q   <= 1'b0;
            forced_q <= 1'b0;
            irq_q    <= 1'b0;
            trig_q   <= '0;
        end else begin
            irq_q <= done_go;
            if (arm_go) begin
                done_q   <= 1'b0;
                forced_q <= 1'b0;
            end else begin
                if (done_go) begin
                    done_q <= 1'b1;
                end
                if (fire) begin
                    trig_q   <= wr_addr;
                    forced_q <= !real_hit;
                end
            end
        end
    end

    assign buf_we       = we_q;
    assign buf_addr     = addr_q;
    assign buf_wdata    = wdata_q;
    assign st_busy      = busy;
    assign st_done      = done_q;
    assign st_forced    = forced_q;
    assign st_trig_addr = trig_q;
    assign st_state     = state_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_ad9280_trig_ctrl.sv
// Directed bench for the AD9280 capture sequencer.
// Expected values are hand-derived from ramp/constant stimulus.
module tb_ad9280_trig_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  adc_data;
    logic        adc_valid;
    logic        cfg_arm;
    logic        cfg_abort;
    logic [7:0]  cfg_level;
    logic        cfg_edge;
    logic        cfg_auto;
    logic [9:0]  cfg_pre_len;
    logic [15:0] cfg_decim;
    logic [23:0] cfg_timeout;
    logic        buf_we;
    logic [9:0]  buf_addr;
    logic [7:0]  buf_wdata;
    logic        st_busy;
    logic        st_done;
    logic        st_forced;
    logic [9:0]  st_trig_addr;
    logic [2:0]  st_state;
    logic        irq;

    ad9280_trig_ctrl dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .cfg_arm      (cfg_arm),
        .cfg_abort    (cfg_abort),
        .cfg_level    (cfg_level),
        .cfg_edge     (cfg_edge),
        .cfg_auto     (cfg_auto),
        .cfg_pre_len  (cfg_pre_len),
        .cfg_decim    (cfg_decim),
        .cfg_timeout  (cfg_timeout),
        .buf_we       (buf_we),
        .buf_addr     (buf_addr),
        .buf_wdata    (buf_wdata),
        .st_busy      (st_busy),
        .st_done      (st_done),
        .st_forced    (st_forced),
        .st_trig_addr (st_trig_addr),
        .st_state     (st_state),
        .irq          (irq)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;

    // Monitor state, written only by the monitor process.
    int         we_cnt, post_we, irq_cnt, gap_bad;
    bit         saw_pre, wrap_seen, have_last;
    logic [7:0] last_d, trig_d, trig_prev;
    logic [9:0] last_a, trig_a;

    // Driven by the stimulus process only.
    bit         mon_clr = 1'b0;
    logic [7:0] step = 8'd1;
    int         rst_base = 0;
    bit         rst_done = 1'b0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h",
                     tag, got, exp);
        end
    endtask

    // Observe writes/irq on the falling edge.
    always @(negedge ACLK) begin
        if (mon_clr) begin
            we_cnt    = 0;
            post_we   = 0;
            irq_cnt   = 0;
            gap_bad   = 0;
            saw_pre   = 1'b0;
            wrap_seen = 1'b0;
            have_last = 1'b0;
        end else begin
            if (buf_we) begin
                if (st_state == 3'd3 && post_we == 0) begin
                    trig_d    = buf_wdata;
                    trig_prev = last_d;
                    trig_a    = buf_addr;
                end
                if (have_last && buf_wdata != 8'(last_d + step))
                    gap_bad++;
                if (have_last && last_a == 10'd1023
                    && buf_addr == 10'd0)
                    wrap_seen = 1'b1;
                we_cnt++;
                if (st_state == 3'd3) post_we++;
                have_last = 1'b1;
                last_d    = buf_wdata;
                last_a    = buf_addr;
            end
            if (irq) irq_cnt++;
            if (st_state == 3'd1) saw_pre = 1'b1;
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        repeat (2) tick();
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge ACLK);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic arm(input logic [7:0]  lvl,
                       input logic        edg,
                       input logic        aut,
                       input logic [9:0]  pre,
                       input logic [15:0] dec,
                       input logic [23:0] tmo);
        cfg_level   = lvl;
        cfg_edge    = edg;
        cfg_auto    = aut;
        cfg_pre_len = pre;
        cfg_decim   = dec;
        cfg_timeout = tmo;
        adc_valid   = 1'b0;
        cfg_arm     = 1'b1;
        tick();
        cfg_arm = 1'b0;
    endtask

    // mode 0: plain; 1: arm pulse in POST; 2: reset in POST
    task automatic stream(input int max_cyc,
                          input logic [7:0] start,
                          input logic [7:0] inc,
                          input int mode);
        logic [7:0] d;
        int  npost;
        bit  poked;
        d     = start;
        npost = 0;
        poked = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (st_done) break;
            adc_valid = 1'b1;
            adc_data  = d;
            if (mode != 0 && !poked && st_state == 3'd3) begin
                npost++;
                if (npost == 50) begin
                    poked = 1'b1;
                    if (mode == 1) cfg_arm = 1'b1;
                    else ARESET = 1'b1;
                end
            end
            tick();
            d = 8'(d + inc);
            if (mode == 1 && cfg_arm) begin
                cfg_arm = 1'b0;
                chk("arm_in_post", st_state, 3);
            end
            if (mode == 2 && poked) begin
                ARESET = 1'b0;
                rst_done = 1'b1;
                chk("rst_we", buf_we, 0);
                chk("rst_addr", buf_addr, 0);
                chk("rst_wdata", buf_wdata, 0);
                chk("rst_state", st_state, 0);
                chk("rst_busy", st_busy, 0);
                chk("rst_trig", st_trig_addr, 0);
                chk("rst_irq", irq, 0);
                rst_base = we_cnt;
                break;
            end
        end
        adc_valid = 1'b0;
    endtask

    initial begin
        ARESET      = 1'b1;
        adc_data    = '0;
        adc_valid   = 1'b0;
        cfg_arm     = 1'b0;
        cfg_abort   = 1'b0;
        cfg_level   = '0;
        cfg_edge    = 1'b0;
        cfg_auto    = 1'b0;
        cfg_pre_len = '0;
        cfg_decim   = '0;
        cfg_timeout = '0;
        repeat (3) tick();
        chk("reset_outs",
            {buf_we, buf_addr, buf_wdata, st_busy, st_done,
             st_forced, st_trig_addr, st_state, irq}, 0);
        ARESET = 1'b0;
        tick();

        // Rising trigger right after 100 pre samples
        clear_mon();
        step = 8'd1;
        arm(8'h80, 1'b0, 1'b0, 10'd100, 16'd0, 24'd0);
        chk("t1_pre_state", st_state, 1);
        chk("t1_busy", st_busy, 1);
        stream(2000, 8'd28, 8'd1, 1);
        settle();
        chk("t1_done", st_done, 1);
        chk("t1_state", st_state, 4);
        chk("t1_we_cnt", we_cnt, 1024);
        chk("t1_post_we", post_we, 924);
        chk("t1_trig_addr", st_trig_addr, 100);
        chk("t1_trig_a", trig_a, 100);
        chk("t1_trig_d", trig_d, 8'h80);
        chk("t1_trig_prev", trig_prev, 8'h7f);
        chk("t1_irq_cnt", irq_cnt, 1);
        chk("t1_forced", st_forced, 0);
        chk("t1_gap", gap_bad, 0);

        // Re-arm from DONE, then abort+arm together
        arm(8'h80, 1'b0, 1'b0, 10'd0, 16'd0, 24'd0);
        chk("rearm_done_clr", st_done, 0);
        chk("rearm_state", st_state, 2);
        cfg_abort = 1'b1;
        cfg_arm   = 1'b1;
        tick();
        chk("abort_arm_wait", st_state, 0);
        tick();
        chk("abort_arm_idle", st_state, 0);
        cfg_abort = 1'b0;
        cfg_arm   = 1'b0;
        settle();
        chk("abort_no_irq", irq_cnt, 1);
        chk("abort_done", st_done, 0);

        // Falling edge, decim 3, pre 0
        clear_mon();
        step = 8'd4;
        arm(8'h80, 1'b1, 1'b0, 10'd0, 16'd3, 24'd0);
        chk("t2_wait_state", st_state, 2);
        stream(6000, 8'd0, 8'd1, 0);
        settle();
        chk("t2_done", st_done, 1);
        chk("t2_no_pre", saw_pre, 0);
        chk("t2_we_cnt", we_cnt, 1088);
        chk("t2_post_we", post_we, 1024);
        chk("t2_trig_addr", st_trig_addr, 64);
        chk("t2_trig_d", trig_d, 8'h00);
        chk("t2_trig_prev", trig_prev, 8'hfc);
        chk("t2_gap", gap_bad, 0);
        chk("t2_forced", st_forced, 0);
        chk("t2_irq_cnt", irq_cnt, 1);

        // Auto mode forced trigger
        clear_mon();
        step = 8'd0;
        arm(8'h80, 1'b0, 1'b1, 10'd10, 16'd0, 24'd500);
        stream(3000, 8'h10, 8'd0, 0);
        settle();
        chk("t3_done", st_done, 1);
        chk("t3_forced", st_forced, 1);
        chk("t3_trig_addr", st_trig_addr, 510);
        chk("t3_we_cnt", we_cnt, 1524);
        chk("t3_post_we", post_we, 1014);
        chk("t3_trig_d", trig_d, 8'h10);
        chk("t3_irq_cnt", irq_cnt, 1);

        // Abort in WAIT, then full pre-depth capture
        clear_mon();
        arm(8'h80, 1'b0, 1'b0, 10'd10, 16'd0, 24'd0);
        stream(100, 8'h10, 8'd0, 0);
        chk("t4_in_wait", st_state, 2);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("t4_abort_idle", st_state, 0);
        settle();
        chk("t4_abort_irq", irq_cnt, 0);
        chk("t4_abort_done", st_done, 0);
        clear_mon();
        step = 8'd1;
        arm(8'h80, 1'b0, 1'b0, 10'd1023, 16'd0, 24'd0);
        chk("t4_pre_state", st_state, 1);
        stream(3000, 8'd0, 8'd1, 0);
        settle();
        chk("t4_done", st_done, 1);
        chk("t4_trig_addr", st_trig_addr, 128);
        chk("t4_post_we", post_we, 1);
        chk("t4_we_cnt", we_cnt, 1153);
        chk("t4_wrap", wrap_seen, 1);
        chk("t4_trig_d", trig_d, 8'h80);
        chk("t4_irq_cnt", irq_cnt, 1);

        // Reset in the middle of POST
        clear_mon();
        arm(8'h80, 1'b0, 1'b0, 10'd5, 16'd0, 24'd0);
        stream(3000, 8'd0, 8'd1, 2);
        chk("t5_rst_hit", rst_done, 1);
        adc_valid = 1'b1;
        repeat (20) tick();
        adc_valid = 1'b0;
        settle();
        chk("t5_no_we", we_cnt, rst_base);
        chk("t5_state", st_state, 0);
        chk("t5_done", st_done, 0);
        chk("t5_forced", st_forced, 0);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
